// File: rtl/toggle_arbiter_if.sv
// Requester-side and toggle-side signals of the toggle arbiter.
// master = requesting control logic, slave = the arbiter itself.
interface toggle_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
) ();
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic               enable;
    logic [NUM_REQ-1:0] req;
    logic               trigger;
    logic [NUM_REQ-1:0] ack;
    logic [ID_W-1:0]    grant_id;
    logic               toggle_state;
    logic               busy;

    modport master (
        output enable, req,
        input  trigger, ack, grant_id, toggle_state, busy
    );

    modport slave (
        input  enable, req,
        output trigger, ack, grant_id, toggle_state, busy
    );
endinterface

// File: rtl/toggle_arbiter.sv
// Round-robin arbiter that issues one trigger pulse per grant to a shared toggle
// FSM, enforces a hold-off between pulses and mirrors the toggle state.
module toggle_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned HOLDOFF = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    toggle_arbiter_if.slave  bus
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic               trig_q, trig_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               tog_q, tog_d;
    logic               busy_q, busy_d;
    logic [ID_W-1:0]    winner;

    // First set request at or above the pointer, wrapping around.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [ID_W-1:0]    p);
        logic            found;
        logic [ID_W-1:0] pick;
        found = 1'b0;
        pick  = p;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            int unsigned idx;
            idx = (32'(p) + k) % NUM_REQ;
            if (!found && r[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
        return pick;
    endfunction

    assign winner = rr_pick(bus.req, ptr_q);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gid_d   = gid_q;
        tog_d   = tog_q;
        trig_d  = 1'b0;
        ack_d   = '0;

        case (state_q)
            IDLE: begin
                if (bus.enable && (|bus.req)) begin
                    gid_d   = winner;
                    trig_d  = 1'b1;
                    ack_d   = NUM_REQ'(1) << winner;
                    state_d = FIRE;
                end
            end
            FIRE: begin
                // The downstream FSM samples trigger on this same edge.
                tog_d = ~tog_q;
                if (gid_q == ID_W'(NUM_REQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = gid_q + ID_W'(1);
                end
                if (HOLDOFF == 0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = CNT_W'(HOLDOFF - 1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gid_q   <= '0;
            trig_q  <= 1'b0;
            ack_q   <= '0;
            tog_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gid_q   <= gid_d;
            trig_q  <= trig_d;
            ack_q   <= ack_d;
            tog_q   <= tog_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.trigger      = trig_q;
    assign bus.ack          = ack_q;
    assign bus.grant_id     = gid_q;
    assign bus.toggle_state = tog_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_toggle_arbiter.sv
// Bench for toggle_arbiter: directed scenarios followed by random traffic,
// all checked against a schedule-based reference model.
module tb_toggle_arbiter;
    localparam int NR = 4;
    localparam int H  = 3;

    logic clk;
    logic reset_n;

    toggle_arbiter_if #(.NUM_REQ(NR)) bus ();

    toggle_arbiter #(.NUM_REQ(NR), .HOLDOFF(H)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int errors = 0;

    // Reference model: arbitration edge, pointer, grant and toggle parity.
    int cyc      = 0;
    int arb_edge = -1000;
    int m_ptr    = 0;
    int m_gid    = 0;
    logic m_tog  = 1'b0;
    logic auto_drop = 1'b1;

    int exp_ack;
    logic exp_trig;
    logic exp_busy;

    int   obs_gid[$];
    int   obs_tcyc[$];
    int   obs_ack[$];
    logic obs_tog[$];
    logic prev_trig = 1'b0;
    int   busy_cnt  = 0;
    int   trig_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        obs_gid.delete();
        obs_tcyc.delete();
        obs_ack.delete();
        obs_tog.delete();
        busy_cnt = 0;
        trig_cnt = 0;
    endtask

    task automatic step();
        logic [NR-1:0] r;
        logic          e;
        logic          found;
        r = bus.req;
        e = bus.enable;
        @(posedge clk);
        cyc++;
        if (cyc == arb_edge + 1) begin
            m_tog = ~m_tog;
            m_ptr = (m_gid + 1) % NR;
        end
        if ((cyc >= arb_edge + H + 2) && e && (r != '0)) begin
            found = 1'b0;
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (m_ptr + k) % NR;
                if (!found && r[idx]) begin
                    found = 1'b1;
                    m_gid = idx;
                end
            end
            arb_edge = cyc;
        end
        exp_trig = (cyc == arb_edge);
        exp_ack  = exp_trig ? (1 << m_gid) : 0;
        exp_busy = (cyc >= arb_edge) && (cyc <= arb_edge + H);
        #1;
        chk("trigger",      32'(bus.trigger),      32'(exp_trig));
        chk("ack",          32'(bus.ack),          32'(exp_ack));
        chk("grant_id",     32'(bus.grant_id),     32'(m_gid));
        chk("toggle_state", 32'(bus.toggle_state), 32'(m_tog));
        chk("busy",         32'(bus.busy),         32'(exp_busy));
        if (prev_trig) obs_tog.push_back(bus.toggle_state);
        if (bus.trigger) begin
            obs_gid.push_back(int'(bus.grant_id));
            obs_ack.push_back(int'(bus.ack));
            obs_tcyc.push_back(cyc);
            trig_cnt++;
        end
        if (bus.busy) busy_cnt++;
        prev_trig = bus.trigger;
        if (auto_drop) bus.req = bus.req & ~NR'(exp_ack);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_trigger"}, 32'(bus.trigger),      32'd0);
        chk({tag, "_ack"},     32'(bus.ack),          32'd0);
        chk({tag, "_gid"},     32'(bus.grant_id),     32'd0);
        chk({tag, "_toggle"},  32'(bus.toggle_state), 32'd0);
        chk({tag, "_busy"},    32'(bus.busy),         32'd0);
    endtask

    task automatic model_reset();
        arb_edge  = -1000;
        m_ptr     = 0;
        m_gid     = 0;
        m_tog     = 1'b0;
        prev_trig = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int start_cyc;
        reset_n    = 1'b0;
        bus.req    = '1;
        bus.enable = 1'b1;

        // Reset held with all requests pending.
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // Fairness with all requests held: 0,1,2,3,0 every HOLDOFF+2 cycles.
        auto_drop = 1'b0;
        clear_obs();
        run(25);
        chk("rr_count", 32'(obs_gid.size()), 32'd5);
        for (int i = 0; i < 5 && i < obs_gid.size(); i++) begin
            chk("rr_order", 32'(obs_gid[i]), 32'(i % NR));
            if (i < obs_tog.size()) chk("rr_toggle", 32'(obs_tog[i]), 32'((i % 2) == 0));
            if (i > 0) chk("rr_spacing", 32'(obs_tcyc[i] - obs_tcyc[i-1]), 32'(H + 2));
        end
        auto_drop = 1'b1;
        bus.req = '0;
        run(6);

        // Single request: one-cycle latency, busy for HOLDOFF+1 cycles.
        clear_obs();
        start_cyc = cyc;
        bus.req = 4'b0100;
        run(8);
        chk("single_count", 32'(obs_gid.size()), 32'd1);
        if (obs_gid.size() > 0) begin
            chk("single_gid",  32'(obs_gid[0]),  32'd2);
            chk("single_ack",  32'(obs_ack[0]),  32'h4);
            chk("single_lat",  32'(obs_tcyc[0]), 32'(start_cyc + 1));
        end
        chk("single_busy", 32'(busy_cnt), 32'(H + 1));

        // Wrap and skip: after grant 3, 0101 serves 0 then 2.
        bus.req = 4'b1000;
        run(6);
        clear_obs();
        bus.req = 4'b0101;
        run(12);
        chk("wrap_count", 32'(obs_gid.size()), 32'd2);
        if (obs_gid.size() > 1) begin
            chk("wrap_first",  32'(obs_gid[0]), 32'd0);
            chk("wrap_second", 32'(obs_gid[1]), 32'd2);
        end

        // Enable dropped during hold: no trigger until re-enabled.
        bus.req = 4'b0001;
        run(2);
        bus.enable = 1'b0;
        bus.req = bus.req | 4'b0010;
        clear_obs();
        run(8);
        chk("gated_triggers", 32'(trig_cnt), 32'd0);
        chk("gated_busy",     32'(bus.busy), 32'd0);
        bus.enable = 1'b1;
        step();
        chk("reenable_trigger", 32'(bus.trigger), 32'd1);
        chk("reenable_ack",     32'(bus.ack),     32'h2);
        bus.req = '0;
        run(6);

        // Asynchronous reset in the middle of FIRE.
        bus.req = 4'b0100;
        step();
        chk("pre_reset_trigger", 32'(bus.trigger), 32'd1);
        #3;
        reset_n = 1'b0;
        bus.req = '1;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        @(negedge clk);
        bus.req = '0;
        reset_n = 1'b1;
        model_reset();
        clear_obs();
        run(4);
        chk("post_reset_triggers", 32'(trig_cnt), 32'd0);
        bus.req = 4'b0011;
        step();
        chk("post_reset_ptr", 32'(bus.grant_id), 32'd0);
        run(6);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) bus.req = bus.req | NR'($urandom);
            if ($urandom_range(0, 15) == 0) bus.req = bus.req & ~(NR'(1) << $urandom_range(0, NR - 1));
            bus.enable = ($urandom_range(0, 7) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
